// File: rtl/periph_arb_pkg.sv
// Shared definitions for the two-requester peripheral bus arbiter.
// Optional feature macro: PERIPH_ARB_RR_EN (round-robin on simultaneous requests).
package periph_arb_pkg;

  // FSM state encoding, kept as plain constants so older tools and
  // netlist-level debug see stable, readable values.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t ISSUE   = 2'd1;
  localparam arb_state_t CAPTURE = 2'd2;
  localparam arb_state_t RESP    = 2'd3;

  // Requester indices. A winner is stored as a single index bit.
  localparam logic IDX_M0 = 1'b0;
  localparam logic IDX_M1 = 1'b1;

  // Last-winner pointer value after reset: m1, so the first contended
  // request goes to m0.
  localparam logic LAST_RST = IDX_M1;

  // One-hot grant (bit n = requester n) to requester index.
  function automatic logic onehot_to_idx(input logic [1:0] oh);
    return oh[1] ? IDX_M1 : IDX_M0;
  endfunction

endpackage

// File: rtl/periph_arb_pick.sv
// Winner selection for the peripheral bus arbiter: two request bits in,
// one-hot grant out. With PERIPH_ARB_RR_EN defined, a simultaneous request
// goes to the requester that did not win last time; otherwise m0 wins.
module periph_arb_pick
  import periph_arb_pkg::*;
(
`ifdef PERIPH_ARB_RR_EN
  input  logic       last_i,
`endif
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // Pick exactly one requester when any is pending.
  always_comb begin
    // NOTE: assign every always_comb output a default first; a path that
    // leaves it unassigned would infer a latch.
    gnt_o = req_i;
    if (req_i == 2'b11) begin
`ifdef PERIPH_ARB_RR_EN
      gnt_o = (last_i == IDX_M0) ? 2'b10 : 2'b01;
`else
      gnt_o = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter onto a single-outstanding peripheral bus (clkCPU domain).
// Each access runs IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE; the peripheral
// returns read data one cycle after bus_en, captured into the winner's dout.
// Optional feature macro: PERIPH_ARB_RR_EN (round-robin on simultaneous
// requests; when undefined m0 always wins and no pointer is kept).
module periph_bus_arbiter
  import periph_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_din,
  input  logic [3:0]        m0_we,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [31:0]       m0_dout,
  // requester 1
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_din,
  input  logic [3:0]        m1_we,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [31:0]       m1_dout,
  // peripheral bus
  output logic              bus_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_din,
  output logic [3:0]        bus_we,
  input  logic [31:0]       bus_dout,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              win_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [3:0]        we_q;
  logic [31:0]       m0_dout_q, m1_dout_q;

  logic [1:0]        pick_gnt;
  logic              take;
  logic              win_idx;

`ifdef PERIPH_ARB_RR_EN
  logic              last_q;
`endif

  periph_arb_pick u_pick (
`ifdef PERIPH_ARB_RR_EN
    .last_i (last_q),
`endif
    .req_i  ({m1_req, m0_req}),
    .gnt_o  (pick_gnt)
  );

  // Requests are only looked at in IDLE; everything after that runs from
  // the latched copy so requesters may change or drop their inputs freely.
  assign take    = (state_q == IDLE) && (|pick_gnt);
  assign win_idx = onehot_to_idx(pick_gnt);

  // Fixed four-state walk; only IDLE waits on a request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access without an ack.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples the pre-edge values, independent of block order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the winner and its access at the IDLE->ISSUE edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these datapath registers are reset because bus_addr/bus_din are
    // visible outputs required to read zero after reset, not just don't-care.
    if (rst) begin
      win_q  <= IDX_M0;
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= '0;
    end else if (take) begin
      win_q  <= win_idx;
      addr_q <= (win_idx == IDX_M1) ? m1_addr : m0_addr;
      din_q  <= (win_idx == IDX_M1) ? m1_din  : m0_din;
      we_q   <= (win_idx == IDX_M1) ? m1_we   : m0_we;
    end
  end

`ifdef PERIPH_ARB_RR_EN
  // Remember who won last so the next tie goes to the other requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_q <= LAST_RST;
    else if (take) last_q <= win_idx;
  end
`endif

  // Capture peripheral read data into the winner's dout at CAPTURE->RESP;
  // each dout holds until that requester's next RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_dout_q <= '0;
      m1_dout_q <= '0;
    end else if (state_q == CAPTURE) begin
      if (win_q == IDX_M1) m1_dout_q <= bus_dout;
      else                 m0_dout_q <= bus_dout;
    end
  end

  // Bus strobe and write enables are live only in ISSUE; address and data
  // simply hold the latched values.
  assign bus_en   = (state_q == ISSUE);
  assign bus_we   = (state_q == ISSUE) ? we_q : 4'h0;
  assign bus_addr = addr_q;
  assign bus_din  = din_q;

  assign busy     = (state_q != IDLE);

  assign m0_gnt   = busy && (win_q == IDX_M0);
  assign m1_gnt   = busy && (win_q == IDX_M1);
  assign m0_ack   = (state_q == RESP) && (win_q == IDX_M0);
  assign m1_ack   = (state_q == RESP) && (win_q == IDX_M1);
  assign m0_dout  = m0_dout_q;
  assign m1_dout  = m1_dout_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: directed scenarios followed by
// random request traffic, all compared against a transaction-phase model.
// Honours PERIPH_ARB_RR_EN for the expected arbitration order.
module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_din = '0, m1_din = '0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack;
  logic [31:0] m0_dout, m1_dout;
  logic        bus_en;
  logic [31:0] bus_addr, bus_din;
  logic [3:0]  bus_we;
  logic [31:0] bus_dout = '0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  periph_bus_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_dout(m1_dout),
    .bus_en(bus_en), .bus_addr(bus_addr), .bus_din(bus_din), .bus_we(bus_we),
    .bus_dout(bus_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Peripheral: registered read data, one cycle after bus_en.
  function automatic logic [31:0] periph_rd(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000A5A5;
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  always @(posedge clk) if (bus_en) bus_dout <= periph_rd(bus_addr);

  // ---------------- reference model ----------------
  // phase: cycles since the accepting edge (0 = idle, 1..3 = in flight)
  int          phase = 0;
  int          win = 0;
  int          last = 1;
  logic [31:0] w_addr, w_din;
  logic [3:0]  w_we;
  logic [31:0] exp_dout [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; last = 1; win = 0;
    exp_dout[0] = '0; exp_dout[1] = '0;
  endtask

  task automatic check_outputs();
    check("bus_en", bus_en, phase == 1);
    check("bus_we", bus_we, (phase == 1) ? w_we : 4'h0);
    if (phase == 1) begin
      check("bus_addr", bus_addr, w_addr);
      check("bus_din", bus_din, w_din);
    end
    check("busy", busy, phase != 0);
    check("m0_gnt", m0_gnt, (phase != 0) && (win == 0));
    check("m1_gnt", m1_gnt, (phase != 0) && (win == 1));
    check("m0_ack", m0_ack, (phase == 3) && (win == 0));
    check("m1_ack", m1_ack, (phase == 3) && (win == 1));
    check("m0_dout", m0_dout, exp_dout[0]);
    check("m1_dout", m1_dout, exp_dout[1]);
  endtask

  // One clock: apply the arbitration rules to the inputs seen at the edge,
  // then compare all outputs 1ns later.
  task automatic clk_step();
    logic r0, r1;
    r0 = m0_req; r1 = m1_req;
    @(posedge clk);
    if (phase == 0) begin
      if (r0 || r1) begin
`ifdef PERIPH_ARB_RR_EN
        if (r0 && r1) win = 1 - last;
        else          win = r1 ? 1 : 0;
`else
        win = r0 ? 0 : 1;
`endif
        last   = win;
        w_addr = (win == 1) ? m1_addr : m0_addr;
        w_din  = (win == 1) ? m1_din  : m0_din;
        w_we   = (win == 1) ? m1_we   : m0_we;
        phase  = 1;
      end
    end else if (phase == 3) begin
      phase = 0;
    end else begin
      phase = phase + 1;
      if (phase == 3) exp_dout[win] = periph_rd(w_addr);
    end
    #1;
    check_outputs();
  endtask

  task automatic check_reset_vals();
    check("rst_bus_en", bus_en, 1'b0);
    check("rst_bus_we", bus_we, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
    check("rst_ack", {m1_ack, m0_ack}, 2'b00);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_din", bus_din, 32'h0);
    check("rst_m0_dout", m0_dout, 32'h0);
    check("rst_m1_dout", m1_dout, 32'h0);
  endtask

  // Assert reset asynchronously (mid-cycle), check immediately, release
  // after one edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_vals();
    @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
  endtask

  // Step until the given requester is acked (bounded); requester drops req
  // on ack. lat = number of edges from the sampling edge to the ack cycle.
  task automatic wait_ack(input int who, output int lat);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      lat++;
      if ((who == 0 && m0_ack) || (who == 1 && m1_ack)) begin
        if (who == 0) m0_req = 1'b0; else m1_req = 1'b0;
        return;
      end
    end
    check("ack_timeout", 1'b0, 1'b1);
    lat = -1;
  endtask

  initial begin
    int lat;
    int order [3];
    int n_ack;

    model_reset();
    w_addr = '0; w_din = '0; w_we = '0;

    // Reset state
    apply_reset();

    // Idle with no requests
    clk_step();
    clk_step();

    // Single read: m0 reads 0x00
    m0_addr = 32'h0; m0_we = 4'h0; m0_din = 32'hDEAD0000; m0_req = 1'b1;
    wait_ack(0, lat);
    check("read_latency", lat, 3);
    check("read_m0_dout", m0_dout, 32'h0000A5A5);
    clk_step();

    // Single write: m1 writes 0x12345678 to 0x0C, we=3
    m1_addr = 32'h0C; m1_din = 32'h12345678; m1_we = 4'h3; m1_req = 1'b1;
    clk_step();
    check("write_bus_we", bus_we, 4'h3);
    check("write_bus_din", bus_din, 32'h12345678);
    m1_we = 4'h0; m1_din = 32'h0; // later changes must be ignored
    lat = 1;
    for (int i = 0; i < 5 && !m1_ack; i++) begin clk_step(); lat++; end
    check("write_latency", lat, 3);
    m1_req = 1'b0;
    clk_step();

    // Contention: both request together and hold for 3 rounds
    m0_addr = 32'h40; m0_we = 4'h0; m1_addr = 32'h80; m1_we = 4'h0;
    m0_req = 1'b1; m1_req = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 20 && n_ack < 3; i++) begin
      clk_step();
      if (m0_ack) begin order[n_ack] = 0; n_ack++; end
      else if (m1_ack) begin order[n_ack] = 1; n_ack++; end
      if (n_ack == 3) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
    check("contend_count", n_ack, 3);
`ifdef PERIPH_ARB_RR_EN
    check("contend_order", {order[0][1:0], order[1][1:0], order[2][1:0]}, {2'd0, 2'd1, 2'd0});
`else
    check("contend_order", {order[0][1:0], order[1][1:0], order[2][1:0]}, {2'd0, 2'd0, 2'd0});
`endif
    clk_step();
    clk_step();
    check("contend_idle", busy, 1'b0);

    // Mid-transaction drop: m1 drops req in ISSUE
    m1_addr = 32'h100; m1_we = 4'h0; m1_req = 1'b1;
    clk_step();
    check("drop_in_issue", bus_en, 1'b1);
    m1_req = 1'b0;
    lat = 1;
    for (int i = 0; i < 5 && !m1_ack; i++) begin clk_step(); lat++; end
    check("drop_ack_latency", lat, 3);
    clk_step();
    clk_step();
    check("drop_no_regrant", {busy, m1_gnt, m0_gnt}, 3'b000);

    // Reset in CAPTURE, then a fresh m0 request completes normally
    m0_addr = 32'h200; m0_we = 4'h0; m0_req = 1'b1;
    clk_step();
    m0_req = 1'b0;
    clk_step();
    check("rst_cap_phase", phase, 2);
    apply_reset();
    clk_step();
    check("post_rst_no_ack", {m1_ack, m0_ack}, 2'b00);
    m0_addr = 32'h0; m0_req = 1'b1;
    wait_ack(0, lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_dout", m0_dout, 32'h0000A5A5);

    // Random traffic: requesters raise at random, occasionally withdraw,
    // always drop on their ack.
    for (int c = 0; c < 400; c++) begin
      if (m0_req) begin
        if ($urandom_range(0, 9) == 0) m0_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        m0_req = 1'b1; m0_addr = $urandom; m0_din = $urandom; m0_we = 4'($urandom);
      end
      if (m1_req) begin
        if ($urandom_range(0, 9) == 0) m1_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        m1_req = 1'b1; m1_addr = $urandom; m1_din = $urandom; m1_we = 4'($urandom);
      end
      clk_step();
      if (m0_ack) m0_req = 1'b0;
      if (m1_ack) m1_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address ports.
REQ-002 SHALL have port clk, input, 1: sole clock, the CPU bus clock (clkCPU domain).
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports m0_req / m1_req, input, 1: requester n wants one bus access.
REQ-005 SHALL have ports m0_addr / m1_addr, input, ADDR_W: access address, held while req is high.
REQ-006 SHALL have ports m0_din / m1_din, input, 32: write data.
REQ-007 SHALL have ports m0_we / m1_we, input, 4: byte write enables; 4'h0 means read.
REQ-008 SHALL have ports m0_gnt / m1_gnt, output, 1: requester owns the bus (ISSUE through RESP).
REQ-009 SHALL have ports m0_ack / m1_ack, output, 1: one-cycle completion pulse.
REQ-010 SHALL have ports m0_dout / m1_dout, output, 32: read data, valid while ack is high.
REQ-011 SHALL have port bus_en, output, 1: peripheral select strobe.
REQ-012 SHALL have ports bus_addr (ADDR_W), bus_din (32), bus_we (4), all outputs: peripheral bus drive.
REQ-013 SHALL have port bus_dout, input, 32: peripheral read data, registered one cycle after bus_en.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE, one cycle in each non-IDLE state.
REQ-016 SHALL leave IDLE on the first edge where any req is high; otherwise it SHALL stay in IDLE.
REQ-017 SHALL latch the winner index, addr, din and we at the IDLE->ISSUE edge; later changes to the request inputs SHALL be ignored.
REQ-018 SHALL drive bus_en=1 with the latched addr, din and we only in ISSUE; in all other states bus_en=0 and bus_we=0.
REQ-019 SHALL register bus_dout at the CAPTURE->RESP edge into the winner's dout.
REQ-020 SHALL assert the winner's ack in RESP only, for exactly one cycle, for both reads and writes.
REQ-021 SHALL assert the winner's gnt from ISSUE through RESP; the loser's gnt and ack SHALL stay 0.
REQ-022 SHALL complete every transaction in 3 cycles from grant to ack (ack in the 3rd cycle after the IDLE sampling edge), with a 4-cycle minimum spacing between transactions.
REQ-023 SHALL complete a transaction and issue its ack even if req drops mid-transaction; transactions SHALL never be aborted.
REQ-024 SHALL hold m*_dout from the last completed transaction until that requester's next RESP.
REQ-025 SHALL NOT sample requests in RESP; requesters drop req on ack, and IDLE re-arbitrates on the next cycle.

Reset
REQ-026 SHALL, on rst, immediately put state=IDLE; set bus_en, bus_we, all gnt, all ack and busy to 0; clear bus_addr, bus_din, m0_dout and m1_dout to 0; and set the last-winner pointer to 1.
REQ-027 SHALL abandon an in-flight access on rst assertion, issuing no ack, and SHALL accept a new request on the first edge after rst deasserts.

Configuration
REQ-028 SHALL use macro PERIPH_ARB_RR_EN: when defined, a simultaneous request SHALL be granted to the requester that is not the last winner (round-robin); when undefined, m0 SHALL always win and the pointer SHALL be removed.

Structure
REQ-029 SHALL place the state enum (IDLE, ISSUE, CAPTURE, RESP) and the requester-index constants in shared package periph_arb_pkg.
REQ-030 SHALL implement the winner selection (two requests plus pointer in, one-hot grant out) in sub-module periph_arb_pick.

Verification
REQ-031 SHALL test a single read: m0 read of 0x00 with bus_dout=0x0000A5A5 in CAPTURE -> bus_en 1 cycle, m0_ack in the 3rd cycle, m0_dout=0x0000A5A5.
REQ-032 SHALL test a single write: m1 writes 0x12345678 to 0x0C with we=4'h3 -> bus_we=4'h3 and bus_din=0x12345678 during ISSUE only, then m1_ack.
REQ-033 SHALL test contention: m0 and m1 request in the same cycle, 3 rounds, holding req -> with RR_EN the order is m0,m1,m0; without it the order is m0,m0,m0.
REQ-034 SHALL test a mid-transaction drop: m1 drops req in ISSUE -> m1_ack still pulses in RESP, and the next IDLE grants nothing.
REQ-035 SHALL test reset in CAPTURE: rst pulse -> bus_en=0, busy=0, no ack; a new m0 request afterwards completes normally with a 3-cycle ack.
